y_bit_packer: RTL
=================

// Module: y_bit_packer
// PURPOSE
//  Downstream consumer of the XOR stage's 1-bit y stream (y_data/y_en/y_rdy).
//  Packs accepted bits LSB-first into WIDTH-bit words and buffers them in a DEPTH-entry FIFO.
//  Presents words on an en/rdy word interface, using the same handshake rules as the bit side.
//  A flush request emits a zero-padded partial word.
// PARAMETERS
//  WIDTH  8  bits per packed word (>=2)
//  DEPTH  4  FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1                   clock
//  reset_n    in   1                   asynchronous, active-low reset
//  in_data    in   1                   bit from upstream y_data
//  in_en      in   1                   bit valid (upstream y_en)
//  in_rdy     out  1                   bit accepted when in_en&&in_rdy (drives upstream y_rdy)
//  flush      in   1                   1-cycle pulse: close the current partial word
//  out_data   out  WIDTH               head word; bit k = k-th accepted bit of that word
//  out_len    out  $clog2(WIDTH+1)     number of valid bits in out_data (1..WIDTH)
//  out_en     out  1                   head word valid
//  out_rdy    in   1                   consumer ready; pop when out_en&&out_rdy
//  out_parity out  1                   XOR of out_data (present only with BITPACK_PARITY_EN)
// BEHAVIOUR
//  - Reset (async): bit_cnt=0, assembly reg=0, FIFO empty, flush_pend=0;
//    out_en=0, out_data=0, out_len=0, out_parity=0, in_rdy=0 while reset_n=0.
//  - in_rdy = !fifo_full && !flush_pend. Combinational from state only; no path from out_rdy.
//  - Bit accept: bit stored at assembly[bit_cnt]; bit_cnt++.
//  - On accepting bit WIDTH: {assembly|bit, len=WIDTH} is pushed at the same edge; bit_cnt->0.
//  - Latency: out_en rises the cycle after the edge that accepted the last bit (FIFO empty case).
//  - flush with bit_cnt==0 and no bit accepted that cycle: no-op.
//  - flush with a bit accepted in the same cycle:
//    - The bit is included first.
//    - If that bit completes the word, the normal full push happens and no extra empty word is produced.
//  - flush with bits pending: pushes {zero-padded assembly, len=bit_cnt}; bit_cnt->0.
//    - If the FIFO is full, flush_pend=1 and in_rdy=0.
//    - The push happens at the first edge with space; flush_pend then clears.
//  - FIFO: out_en = !empty; out_data/out_len/out_parity are driven from the head entry and are
//    stable while out_en && !out_rdy.
//  - Simultaneous push+pop when full: the pop frees a slot, but in_rdy was already 0, so no push
//    occurs that cycle. in_rdy rises next cycle.
//  - Simultaneous push+pop otherwise: occupancy unchanged. Pointers wrap modulo DEPTH.
//  - Holding words: out_data/out_len hold their last value while empty (out_en=0 qualifies).
//  - Reset mid-operation discards the partial word and all buffered words.
// CONFIGURATION
//  BITPACK_PARITY_EN defined:
//    - Each FIFO entry stores parity (XOR of the valid bits).
//    - The out_parity port exists and tracks the head entry.
//  BITPACK_PARITY_EN undefined: no port, no storage, and behaviour is otherwise identical.
// STRUCTURE
//  Package bitpack_pkg holds:
//    - default WIDTH/DEPTH constants;
//    - LEN_W = $clog2(WIDTH+1);
//    - the FIFO entry struct {data, len[, parity]}.
//  Sub-module bitpack_fifo: sync FIFO of entries (push/pop/full/empty/head).
//  The top holds the assembly register, the bit counter and the flush logic.
// TESTING  (WIDTH=8, DEPTH=4)
//  1. Bits 1,0,1,1,0,0,1,0 with out_rdy=1:
//     one word out_data=8'h4D, out_len=8, out_en high 1 cycle after the 8th accept.
//  2. Bits 1,1,0 then flush:
//     out_data=8'h03, out_len=3. A second flush with no new bits produces no word.
//  3. out_rdy=0, stream 32 bits of 1:
//     - 4 words are buffered and in_rdy=0 after the 32nd accept.
//     - The 33rd bit is held.
//     - Pulse out_rdy 1 cycle: 8'hFF popped and in_rdy=1 next cycle.
//  4. FIFO full, 5 bits pending, flush pulse:
//     - flush_pend=1 and in_rdy stays 0.
//     - After one pop, the word len=5 is pushed and in_rdy returns.
//  5. reset_n low mid-word with 2 words buffered:
//     out_en=0 immediately; after release the next 8 bits form a clean word.
//  6. BITPACK_PARITY_EN: 8'h4D gives out_parity=0; 8'h07 (len 3) gives out_parity=1.

Source files
------------

// File: rtl/bitpack_pkg.sv
// bitpack_pkg: shared constants and FIFO entry type for the y-stream bit packer.
// Optional per-word parity storage is enabled by BITPACK_PARITY_EN.
package bitpack_pkg;
    localparam int BP_WIDTH = 8;
    localparam int BP_DEPTH = 4;
    localparam int BP_LEN_W = $clog2(BP_WIDTH + 1);

    typedef struct packed {
        logic [BP_WIDTH-1:0] data;
        logic [BP_LEN_W-1:0] len;
`ifdef BITPACK_PARITY_EN
        logic                parity;
`endif
    } entry_t;
endpackage

// File: rtl/bitpack_fifo.sv
// bitpack_fifo: synchronous FIFO of packed words; head holds the last popped entry while empty.
module bitpack_fifo
    import bitpack_pkg::*;
#(
    parameter type T     = entry_t,
    parameter int  DEPTH = BP_DEPTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_i,
    input  T     wr_data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign cnt_d   = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    // Pointing one slot back while empty keeps the last popped word on the outputs.
    assign head_o  = mem_q[empty_o ? rd_q - 1'b1 : rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= wr_data_i;
            wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/y_bit_packer.sv
// y_bit_packer: packs the accepted 1-bit y stream LSB-first into words, with flush of partial words.
// Define BITPACK_PARITY_EN to store per-word parity and expose out_parity.
module y_bit_packer
    import bitpack_pkg::*;
#(
    parameter int WIDTH = BP_WIDTH,
    parameter int DEPTH = BP_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_data,
    input  logic                         in_en,
    output logic                         in_rdy,
    input  logic                         flush,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(WIDTH+1)-1:0]   out_len,
    output logic                         out_en,
    input  logic                         out_rdy
`ifdef BITPACK_PARITY_EN
    ,
    output logic                         out_parity
`endif
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] len;
`ifdef BITPACK_PARITY_EN
        logic             parity;
`endif
    } word_t;

    logic [WIDTH-1:0] asm_q, asm_d, asm_w;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_w;
    logic             pend_q, pend_d;
    logic             accept, flush_req, push, full, empty;
    word_t            wr_word, head;

    assign in_rdy = reset_n && !full && !pend_q;
    assign accept = in_en && in_rdy;

    always_comb begin
        asm_w     = accept ? asm_q | (WIDTH'(in_data) << cnt_q) : asm_q;
        cnt_w     = cnt_q + LEN_W'(accept);
        flush_req = flush || pend_q;
        // A completed word always pushes; otherwise a flush pushes whatever is pending if there is room.
        push      = cnt_w == LEN_W'(WIDTH) || (flush_req && cnt_w != '0 && !full);
        pend_d    = flush_req && cnt_w != '0 && !push;
        cnt_d     = push ? '0 : cnt_w;
        asm_d     = push ? '0 : asm_w;
        wr_word      = '0;
        wr_word.data = asm_w;
        wr_word.len  = cnt_w;
`ifdef BITPACK_PARITY_EN
        wr_word.parity = ^asm_w;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    bitpack_fifo #(.T(word_t), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_i   (push),
        .wr_data_i(wr_word),
        .pop_i    (out_rdy),
        .full_o   (full),
        .empty_o  (empty),
        .head_o   (head)
    );

    assign out_en   = !empty;
    assign out_data = head.data;
    assign out_len  = head.len;
`ifdef BITPACK_PARITY_EN
    assign out_parity = head.parity;
`endif
endmodule
